// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps at most one request outstanding to a
// multi-cycle instruction memory, and buffers returned words with their PCs in a small
// prefetch queue. Optional performance counters are compiled in with FETCH_PERF_EN.
module fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 2,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [DATA_W-1:0]      imem_addr,
  input  logic                   imem_valid,
  input  logic [DATA_W-1:0]      imem_data,
  output logic                   inst_valid,
  output logic [DATA_W-1:0]      inst,
  output logic [DATA_W-1:0]      inst_pc,
  input  logic                   deq_ready,
  input  logic                   redirect,
  input  logic [DATA_W-1:0]      redirect_pc,
  input  logic                   halt,
  output logic [DATA_W-1:0]      pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]            perf_starve,
  output logic [15:0]            perf_flush,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic               halted_q, halted_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [DATA_W-1:0]  pcs_mem  [DEPTH];

  logic               enq;
  logic               deq_fire;
  logic               halt_eff;
  logic [DATA_W-1:0]  pc_next;
  logic [CNT_W-1:0]   count_after_enq;

  assign deq_fire        = (count_q != '0) && deq_ready;
  assign halt_eff        = halted_q | halt;
  assign pc_next         = pc_q + DATA_W'(PC_INC);
  assign count_after_enq = count_q + CNT_W'(1) - CNT_W'(deq_fire);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    halted_d = halt_eff;
    enq      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!redirect && !halt_eff && (count_q < DEPTH_C)) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          if (imem_valid) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_valid) begin
          enq  = 1'b1;
          pc_d = pc_next;
          if (!halt_eff && (count_after_enq < DEPTH_C)) begin
            addr_d = pc_next;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end
      S_DROP: begin
        // The old request keeps imem_req/imem_addr until the memory completes it.
        if (imem_valid) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    head_d  = deq_fire ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq      ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq_fire);

    if (redirect) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      halted_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // NOTE: queue storage is not reset; the outputs below are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[tail_q] <= imem_data;
      pcs_mem[tail_q]  <= addr_q;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? data_mem[head_q] : '0;
  assign inst_pc    = inst_valid ? pcs_mem[head_q]  : '0;
  assign pc         = pc_q;
  assign count      = count_q;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_starve_q, perf_starve_d;
  logic [15:0] perf_flush_q,  perf_flush_d;

  always_comb begin
    perf_starve_d = perf_starve_q;
    perf_flush_d  = perf_flush_q;
    if (!inst_valid && !halted_q && (perf_starve_q != 16'hFFFF)) begin
      perf_starve_d = perf_starve_q + 16'd1;
    end
    if (redirect && (perf_flush_q != 16'hFFFF)) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_starve_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_starve_q <= perf_starve_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_starve = perf_starve_q;
  assign perf_flush  = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model and a behavioural
// memory with selectable latency, driven by directed phases followed by random traffic.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        deq_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] pc;
  logic [2:0]  count;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_starve;
  logic [15:0] perf_flush;
`endif

  fetch_unit #(.DATA_W(16), .DEPTH(DEPTH), .PC_INC(2), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .deq_ready   (deq_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .pc          (pc),
`ifdef FETCH_PERF_EN
    .perf_starve (perf_starve),
    .perf_flush  (perf_flush),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } entry_t;

  // Reference model: instruction queue plus the outstanding-request view of the front end.
  entry_t      mq[$];
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  bit          m_req;
  bit          m_drop;
  bit          m_halted;
  int          m_starve;
  int          m_flush;

  // Behavioural memory
  bit          mem_busy;
  int          mem_left;
  int          lat_mode;
  bit          spur_en;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = 16'h0000;
    m_addr   = 16'h0000;
    m_req    = 0;
    m_drop   = 0;
    m_halted = 0;
    m_starve = 0;
    m_flush  = 0;
    mem_busy = 0;
  endtask

  task automatic step(input bit r, input bit rd, input logic [15:0] rpc,
                      input bit h, input bit dq);
    bit          iv;
    logic [15:0] idat;
    int          sz;
    bit          heff;
    entry_t      e;

    iv   = 0;
    idat = 16'h0000;
    if (m_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_left = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      end
      iv   = (mem_left == 1);
      mem_left--;
      idat = 16'h1000 + m_addr;
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      iv   = 1;
      idat = 16'($urandom);
    end

    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = h;
    deq_ready   = dq;
    imem_valid  = iv;
    imem_data   = idat;

    if (m_req && iv) mem_busy = 0;

    if (r) begin
      model_reset();
    end else begin
      sz   = mq.size();
      heff = m_halted || h;
      if (sz == 0 && !m_halted && m_starve < 65535) m_starve++;
      if (rd && m_flush < 65535) m_flush++;
      if (sz > 0 && dq) void'(mq.pop_front());
      if (rd) begin
        mq.delete();
        if (m_req && iv) begin
          m_req  = 0;
          m_drop = 0;
        end else if (m_req) begin
          m_drop = 1;
        end
        m_pc     = rpc;
        m_halted = 0;
      end else begin
        if (!m_req) begin
          if (!heff && sz < DEPTH) begin
            m_req  = 1;
            m_addr = m_pc;
          end
        end else if (m_drop) begin
          if (iv) begin
            m_req  = 0;
            m_drop = 0;
          end
        end else if (iv) begin
          e.data = idat;
          e.pc   = m_addr;
          mq.push_back(e);
          m_pc = m_pc + 16'd2;
          if (!heff && mq.size() < DEPTH) m_addr = m_pc;
          else m_req = 0;
        end
        m_halted = heff;
      end
    end

    @(posedge clk);
    #1;
    check("imem_req",   {15'b0, imem_req},   {15'b0, m_req});
    check("imem_addr",  imem_addr,           m_addr);
    check("inst_valid", {15'b0, inst_valid}, {15'b0, mq.size() != 0});
    check("inst",       inst,                (mq.size() != 0) ? mq[0].data : 16'h0000);
    check("inst_pc",    inst_pc,             (mq.size() != 0) ? mq[0].pc   : 16'h0000);
    check("pc",         pc,                  m_pc);
    check("count",      {13'b0, count},      16'(mq.size()));
`ifdef FETCH_PERF_EN
    check("perf_starve", perf_starve, 16'(m_starve));
    check("perf_flush",  perf_flush,  16'(m_flush));
`endif
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    imem_valid  = 1'b0;
    imem_data   = 16'h0000;
    deq_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    lat_mode    = 1;
    spur_en     = 0;
    mem_left    = 0;
    model_reset();
    @(negedge clk);

    // Reset state, then streaming with a 1-cycle memory
    step(1, 0, 16'h0, 0, 1);
    step(1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 16'h0, 0, 1);

    // Fill the queue with a 3-cycle memory and no consumer
    step(1, 0, 16'h0, 0, 0);
    lat_mode = 3;
    for (int i = 0; i < 25; i++) step(0, 0, 16'h0, 0, 0);
    check("full_count",   {13'b0, count},   16'd4);
    check("full_req",     {15'b0, imem_req}, 16'd0);
    check("full_head_pc", inst_pc,          16'h0000);

    // Redirect while a request is outstanding, then drain
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 1);
    step(0, 1, 16'h0040, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 16'h0, 0, 1);

    // Redirect coinciding with the response of a 1-cycle memory
    lat_mode = 1;
    step(0, 1, 16'h0080, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 0, 1);

    // Halt pulse mid-request, then resume via redirect
    step(1, 0, 16'h0, 0, 1);
    lat_mode = 2;
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0, 1);
    check("halt_req", {15'b0, imem_req}, 16'd0);
    step(0, 1, 16'h0010, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0, 1);

    // Address wrap across the top of the address space
    lat_mode = 1;
    step(0, 1, 16'hFFFC, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0, 1);

    // Random traffic: variable latency, stalls, redirects, halts, resets, stray responses
    lat_mode = 0;
    spur_en  = 1;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 13) == 0,
           ($urandom_range(0, 3) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
